// File: rtl/vespa_dft_pulse_gen.sv
// -----------------------------------------------------------------------------
// vespa_dft_pulse_gen
//
// Multi-channel DFT pulse generator for the VESPA loop/feedback test path.
// Each channel either runs a programmable burst (H cycles high, L cycles low,
// N pulses; N = 0 runs until stopped) or, in gate mode, drives a registered
// copy of start & ~stop.
//
// Ports:
//   i_clk        sole clock, rising edge
//   i_rst        asynchronous, active-high reset
//   i_start      per-channel launch request (level-sampled)
//   i_stop       per-channel abort/inhibit (level-sampled, dominates start)
//   i_gate_mode  0 = burst mode, 1 = gate mode (examined only in IDLE)
//   i_cfg_high   high cycles per pulse (0 behaves as 1)
//   i_cfg_low    low cycles between pulses (0 behaves as 1)
//   i_cfg_count  pulses per burst (0 = continuous)
//   o_pulse      registered pulse outputs
//   o_busy       channel is executing a burst
//   o_done       1-cycle strobe: burst completed normally
//   o_aborted    1-cycle strobe: burst terminated by stop
//   o_dbg_state  per-channel FSM state, 2 bits per channel (0 IDLE, 1 HIGH, 2 LOW)
//
// Control semantics: there is no valid/ready handshake. start and stop are
// plain levels sampled on every rising edge. A channel accepts start only
// while IDLE with stop low; start seen while busy is ignored, and a start
// still held when a burst finishes launches the next burst on the following
// edge. stop aborts a running burst and suppresses a launch on the same edge.
// -----------------------------------------------------------------------------
module vespa_dft_pulse_gen #(
   parameter int CHANNELS = 4,
   parameter int WIDTH_W  = 8,
   parameter int COUNT_W  = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [CHANNELS-1:0]   i_start,
   input  logic [CHANNELS-1:0]   i_stop,
   input  logic                  i_gate_mode,
   input  logic [WIDTH_W-1:0]    i_cfg_high,
   input  logic [WIDTH_W-1:0]    i_cfg_low,
   input  logic [COUNT_W-1:0]    i_cfg_count,
   output logic [CHANNELS-1:0]   o_pulse,
   output logic [CHANNELS-1:0]   o_busy,
   output logic [CHANNELS-1:0]   o_done,
   output logic [CHANNELS-1:0]   o_aborted,
   output logic [2*CHANNELS-1:0] o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

   // Zero durations are promoted to one cycle so the countdown never stalls.
   logic [WIDTH_W-1:0] w_cfg_h;
   logic [WIDTH_W-1:0] w_cfg_l;

   assign w_cfg_h = (i_cfg_high == '0) ? WIDTH_W'(1) : i_cfg_high;
   assign w_cfg_l = (i_cfg_low  == '0) ? WIDTH_W'(1) : i_cfg_low;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      state_t             r_state;
      state_t             w_state_nxt;
      logic [WIDTH_W-1:0] r_dur;
      logic [WIDTH_W-1:0] w_dur_nxt;
      logic [COUNT_W-1:0] r_rem;
      logic [COUNT_W-1:0] w_rem_nxt;
      logic [WIDTH_W-1:0] r_h;
      logic [WIDTH_W-1:0] r_l;
      logic               r_cont;
      logic               r_gate;
      logic               w_gate_nxt;
      logic               r_done;
      logic               w_done_nxt;
      logic               r_abort;
      logic               w_abort_nxt;
      logic               w_load;

      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            r_state <= ST_IDLE;
            r_dur   <= '0;
            r_rem   <= '0;
            r_h     <= '0;
            r_l     <= '0;
            r_cont  <= 1'b0;
            r_gate  <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_dur   <= w_dur_nxt;
            r_rem   <= w_rem_nxt;
            r_gate  <= w_gate_nxt;
            r_done  <= w_done_nxt;
            r_abort <= w_abort_nxt;
            // Shared cfg values are frozen per channel at launch.
            if (w_load) begin
               r_h    <= w_cfg_h;
               r_l    <= w_cfg_l;
               r_cont <= (i_cfg_count == '0);
            end
         end
      end

      always_comb begin
         w_state_nxt = r_state;
         w_dur_nxt   = r_dur;
         w_rem_nxt   = r_rem;
         w_gate_nxt  = 1'b0;
         w_done_nxt  = 1'b0;
         w_abort_nxt = 1'b0;
         w_load      = 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_gate_mode) begin
                  w_gate_nxt = i_start[g] & ~i_stop[g];
               end else if (i_start[g] && !i_stop[g]) begin
                  w_load      = 1'b1;
                  w_state_nxt = ST_HIGH;
                  w_dur_nxt   = w_cfg_h;
                  w_rem_nxt   = i_cfg_count;
               end
            end
            ST_HIGH: begin
               // stop is checked first so an abort on the last high cycle
               // beats the normal completion.
               if (i_stop[g]) begin
                  w_state_nxt = ST_IDLE;
                  w_abort_nxt = 1'b1;
                  w_dur_nxt   = '0;
               end else if (r_dur <= WIDTH_W'(1)) begin
                  if (!r_cont && r_rem == COUNT_W'(1)) begin
                     w_state_nxt = ST_IDLE;
                     w_done_nxt  = 1'b1;
                     w_dur_nxt   = '0;
                  end else begin
                     w_state_nxt = ST_LOW;
                     w_dur_nxt   = r_l;
                  end
               end else begin
                  w_dur_nxt = r_dur - WIDTH_W'(1);
               end
            end
            ST_LOW: begin
               if (i_stop[g]) begin
                  w_state_nxt = ST_IDLE;
                  w_abort_nxt = 1'b1;
                  w_dur_nxt   = '0;
               end else if (r_dur <= WIDTH_W'(1)) begin
                  w_state_nxt = ST_HIGH;
                  w_dur_nxt   = r_h;
                  // Continuous bursts leave the remaining counter untouched.
                  if (!r_cont) begin
                     w_rem_nxt = r_rem - COUNT_W'(1);
                  end
               end else begin
                  w_dur_nxt = r_dur - WIDTH_W'(1);
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end

      // Pulse is decoded from registered state, so reset clears it at once.
      assign o_pulse[g]           = (r_state == ST_HIGH) | r_gate;
      assign o_busy[g]            = (r_state != ST_IDLE);
      assign o_done[g]            = r_done;
      assign o_aborted[g]         = r_abort;
      assign o_dbg_state[2*g +: 2] = r_state;
   end

endmodule

// File: tb/tb_vespa_dft_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_vespa_dft_pulse_gen
//
// Directed bench for vespa_dft_pulse_gen. A default 4-channel instance covers
// bursts, zero fields, continuous mode, stop, gate mode, priority, relaunch,
// channel independence and reset; a 1-channel 4-bit instance covers the
// maximum-count boundary. Inputs change 1 time unit after a rising edge and
// outputs are observed at that same point, i.e. "cycle j" is the value held
// after the j-th edge following a launch.
// -----------------------------------------------------------------------------
module tb_vespa_dft_pulse_gen;

   logic       clk;
   logic       rst;
   logic [3:0] start;
   logic [3:0] stop;
   logic       gate_mode;
   logic [7:0] cfg_high;
   logic [7:0] cfg_low;
   logic [7:0] cfg_count;
   logic [3:0] pulse;
   logic [3:0] busy;
   logic [3:0] done;
   logic [3:0] aborted;
   logic [7:0] dbg_state;

   logic       s4_start;
   logic       s4_stop;
   logic [3:0] c4_high;
   logic [3:0] c4_low;
   logic [3:0] c4_count;
   logic       p4_pulse;
   logic       p4_busy;
   logic       p4_done;
   logic       p4_aborted;
   logic [1:0] p4_dbg;

   int n_total;
   int n_bad;

   vespa_dft_pulse_gen u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_stop      (stop),
      .i_gate_mode (gate_mode),
      .i_cfg_high  (cfg_high),
      .i_cfg_low   (cfg_low),
      .i_cfg_count (cfg_count),
      .o_pulse     (pulse),
      .o_busy      (busy),
      .o_done      (done),
      .o_aborted   (aborted),
      .o_dbg_state (dbg_state)
   );

   vespa_dft_pulse_gen #(.CHANNELS(1), .WIDTH_W(4), .COUNT_W(4)) u_dut4 (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (s4_start),
      .i_stop      (s4_stop),
      .i_gate_mode (1'b0),
      .i_cfg_high  (c4_high),
      .i_cfg_low   (c4_low),
      .i_cfg_count (c4_count),
      .o_pulse     (p4_pulse),
      .o_busy      (p4_busy),
      .o_done      (p4_done),
      .o_aborted   (p4_aborted),
      .o_dbg_state (p4_dbg)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Checks {pulse,busy,done,aborted} of one channel over n cycles. Vector
   // bit n-1 is the first observed cycle; a tick precedes every cycle but
   // the first.
   task automatic expect_seq(input string name, input int ch, input int n,
                             input logic [31:0] p, input logic [31:0] b,
                             input logic [31:0] d, input logic [31:0] a);
      for (int c = 0; c < n; c++) begin
         int idx;
         if (c > 0) tick();
         idx = n - 1 - c;
         chk($sformatf("%s c%0d", name, c + 1),
             {28'd0, pulse[ch], busy[ch], done[ch], aborted[ch]},
             {28'd0, p[idx], b[idx], d[idx], a[idx]});
      end
   endtask

   // ---------------- driver ----------------
   task automatic launch(input int ch, input logic [7:0] h, input logic [7:0] l,
                         input logic [7:0] n);
      cfg_high  = h;
      cfg_low   = l;
      cfg_count = n;
      start[ch] = 1'b1;
      tick();
      start[ch] = 1'b0;
   endtask

   logic [7:0]  h_tab [4];
   logic [7:0]  l_tab [4];
   logic [7:0]  n_tab [4];
   logic [3:0]  ind_p [11];
   logic [3:0]  ind_d [11];
   logic [4:0]  g_start;
   logic [4:0]  g_stop;
   logic [4:0]  g_pulse;

   initial begin
      n_total   = 0;
      n_bad     = 0;
      rst       = 1'b1;
      start     = '0;
      stop      = '0;
      gate_mode = 1'b0;
      cfg_high  = '0;
      cfg_low   = '0;
      cfg_count = '0;
      s4_start  = 1'b0;
      s4_stop   = 1'b0;
      c4_high   = '0;
      c4_low    = '0;
      c4_count  = '0;

      // Reset state
      tick();
      tick();
      chk("rst pulse",   {28'd0, pulse},   32'd0);
      chk("rst busy",    {28'd0, busy},    32'd0);
      chk("rst done",    {28'd0, done},    32'd0);
      chk("rst aborted", {28'd0, aborted}, 32'd0);
      chk("rst dbg",     {24'd0, dbg_state}, 32'd0);
      rst = 1'b0;
      tick();

      // Burst H=2 L=3 N=3
      launch(0, 8'd2, 8'd3, 8'd3);
      expect_seq("burst233", 0, 13, 32'b1100011000110, 32'b1111111111110,
                 32'b0000000000001, 32'b0);
      tick();
      chk("burst233 after", {28'd0, pulse[0], busy[0], done[0], aborted[0]}, 32'd0);

      // Zero H/L fields, N=2
      launch(0, 8'd0, 8'd0, 8'd2);
      expect_seq("zero_hl", 0, 4, 32'b1010, 32'b1110, 32'b0001, 32'b0);
      tick();

      // Continuous toggle, stopped during a high cycle
      launch(0, 8'd1, 8'd1, 8'd0);
      expect_seq("cont", 0, 5, 32'b10101, 32'b11111, 32'b0, 32'b0);
      stop[0] = 1'b1;
      tick();
      chk("cont stop", {28'd0, pulse[0], busy[0], done[0], aborted[0]}, 32'b0001);
      stop[0] = 1'b0;
      tick();
      chk("cont stop+1", {28'd0, pulse[0], busy[0], done[0], aborted[0]}, 32'b0000);

      // Stop on the final high cycle: abort beats done
      launch(0, 8'd2, 8'd1, 8'd1);
      expect_seq("last_hi", 0, 2, 32'b11, 32'b11, 32'b0, 32'b0);
      stop[0] = 1'b1;
      tick();
      chk("last_hi stop", {28'd0, pulse[0], busy[0], done[0], aborted[0]}, 32'b0001);
      stop[0] = 1'b0;
      tick();

      // Gate mode on channel 1
      gate_mode = 1'b1;
      g_start   = 5'b11110;
      g_stop    = 5'b00100;
      g_pulse   = 5'b11010;
      for (int c = 0; c < 5; c++) begin
         start[1] = g_start[4 - c];
         stop[1]  = g_stop[4 - c];
         tick();
         chk($sformatf("gate c%0d", c + 1),
             {28'd0, pulse[1], busy[1], done[1], aborted[1]},
             {28'd0, g_pulse[4 - c], 3'b000});
      end
      start[1]  = 1'b0;
      stop[1]   = 1'b0;
      gate_mode = 1'b0;
      tick();

      // start and stop together in IDLE: no launch
      cfg_high  = 8'd2;
      cfg_low   = 8'd1;
      cfg_count = 8'd1;
      start[2]  = 1'b1;
      stop[2]   = 1'b1;
      tick();
      chk("start_stop c1", {28'd0, pulse[2], busy[2], done[2], aborted[2]}, 32'd0);
      start[2] = 1'b0;
      stop[2]  = 1'b0;
      tick();
      chk("start_stop c2", {28'd0, pulse[2], busy[2], done[2], aborted[2]}, 32'd0);

      // Held start relaunches on the cycle after done
      cfg_high  = 8'd1;
      cfg_low   = 8'd1;
      cfg_count = 8'd2;
      start[0]  = 1'b1;
      tick();
      expect_seq("held", 0, 5, 32'b10101, 32'b11101, 32'b00010, 32'b0);
      start[0] = 1'b0;
      tick();
      expect_seq("held2", 0, 3, 32'b010, 32'b110, 32'b001, 32'b0);
      tick();

      // Channel independence with staggered launches and different cfg
      h_tab = '{8'd1, 8'd2, 8'd3, 8'd1};
      l_tab = '{8'd1, 8'd2, 8'd1, 8'd2};
      n_tab = '{8'd2, 8'd2, 8'd1, 8'd3};
      ind_p = '{4'b0001, 4'b0010, 4'b0111, 4'b1100, 4'b0100, 4'b0010,
                4'b1010, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
      ind_d = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0100,
                4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1000};
      for (int j = 0; j < 11; j++) begin
         if (j < 4) begin
            cfg_high  = h_tab[j];
            cfg_low   = l_tab[j];
            cfg_count = n_tab[j];
            start     = 4'b0001 << j;
         end else begin
            cfg_high  = 8'd7;
            cfg_low   = 8'd7;
            cfg_count = 8'd0;
            start     = 4'b0000;
         end
         tick();
         chk($sformatf("indep pulse c%0d", j + 1), {28'd0, pulse}, {28'd0, ind_p[j]});
         chk($sformatf("indep done c%0d", j + 1),  {28'd0, done},  {28'd0, ind_d[j]});
      end
      tick();

      // Reset mid-burst
      launch(0, 8'd3, 8'd1, 8'd1);
      chk("rst_mid pre", {28'd0, pulse[0], busy[0], done[0], aborted[0]}, 32'b1100);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_mid async", {28'd0, pulse, busy, done, aborted} >> 0 & 32'hFFFF, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("rst_mid release", {28'd0, pulse[0], busy[0], done[0], aborted[0]}, 32'd0);
      launch(0, 8'd1, 8'd1, 8'd1);
      chk("rst_mid relaunch", {28'd0, pulse[0], busy[0], done[0], aborted[0]}, 32'b1100);
      tick();
      chk("rst_mid done", {28'd0, pulse[0], busy[0], done[0], aborted[0]}, 32'b0010);

      // Boundary: 4-bit fields at maximum
      begin
         int   busy_cnt;
         int   high_cnt;
         int   rises;
         logic prev;
         busy_cnt = 0;
         high_cnt = 0;
         rises    = 0;
         prev     = 1'b0;
         c4_high  = 4'd15;
         c4_low   = 4'd15;
         c4_count = 4'd15;
         s4_start = 1'b1;
         tick();
         s4_start = 1'b0;
         for (int c = 0; c < 1000; c++) begin
            if (!p4_busy) break;
            busy_cnt++;
            if (p4_pulse) high_cnt++;
            if (p4_pulse && !prev) rises++;
            prev = p4_pulse;
            tick();
         end
         chk("max busy cycles", busy_cnt, 32'd435);
         chk("max high cycles", high_cnt, 32'd225);
         chk("max pulses",      rises,    32'd15);
         chk("max done",    {30'd0, p4_done, p4_pulse}, 32'b10);
         tick();
         chk("max done+1",  {30'd0, p4_done, p4_aborted}, 32'b00);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/vespa_dft_pulse_gen.md
# vespa_dft_pulse_gen

Clocked, multi-channel DFT pulse generator for the VESPA loop/feedback test path. It extends the single start/stop gated pulse cell into CHANNELS independent channels. Each channel either emits a programmable burst of pulses (high width, low gap, pulse count) or, in gate mode, produces a registered `start & ~stop` level. It sits between the DFT controller and the feedback-loop stimulus nets.

## Interface
- CHANNELS, 4, number of independent pulse channels
- WIDTH_W, 8, bit width of the high/low duration fields
- COUNT_W, 8, bit width of the pulse count field

- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  CHANNELS  per-channel launch request, level-sampled
- stop  in  CHANNELS  per-channel abort/inhibit, level-sampled; dominates start
- gate_mode  in  1  0 = burst mode, 1 = gate mode (pulse = registered start & ~stop)
- cfg_high  in  WIDTH_W  high cycles per pulse; 0 treated as 1
- cfg_low  in  WIDTH_W  low cycles between pulses; 0 treated as 1
- cfg_count  in  COUNT_W  pulses per burst; 0 = continuous until stop
- pulse  out  CHANNELS  registered pulse outputs
- busy  out  CHANNELS  channel is executing a burst
- done  out  CHANNELS  1-cycle strobe: burst completed normally
- aborted  out  CHANNELS  1-cycle strobe: burst terminated by stop

## Operation
- Per-channel FSM states: IDLE, HIGH, LOW. Channels are fully independent; shared cfg_* values are captured per channel at launch.
- Reset (async, rst=1):
  - every channel goes to IDLE
  - pulse, busy, done and aborted all 0
  - duration and remaining counters 0
- IDLE, gate_mode=1: next pulse[i] = start[i] & ~stop[i]. State stays IDLE. busy, done and aborted stay 0.
- IDLE, gate_mode=0: pulse[i]=0. When start[i]=1 and stop[i]=0:
  - capture H=max(cfg_high,1), L=max(cfg_low,1) and N=cfg_count
  - next state HIGH
- gate_mode is only examined in IDLE. A change of gate_mode while a channel is busy has no effect until that channel returns to IDLE.
- HIGH: pulse=1, busy=1 for H cycles. At the end of the H cycles:
  - if N≠0 and the remaining count is 1: go to IDLE and assert done for 1 cycle
  - otherwise: go to LOW
- LOW: pulse=0, busy=1 for L cycles. At the end, decrement the remaining count (no decrement when N=0) and go to HIGH.
- start while busy: ignored, including start held high continuously. A new burst needs the channel to be in IDLE with start=1. A held start relaunches on the cycle after done.
- stop[i]=1 in HIGH or LOW:
  - next cycle the channel is IDLE with pulse=0 and busy=0
  - aborted=1 for 1 cycle, done=0
- stop and start both high in IDLE: no launch, no strobe.
- Stop on the same cycle as the final HIGH cycle ends: the abort wins, so aborted=1 and done=0.
- Counter widths:
  - duration counter is WIDTH_W bits and counts down from H or L to 1
  - remaining counter is COUNT_W bits
  - N=2^COUNT_W−1 must complete exactly that many pulses with no wrap
  - with N=0 the remaining counter is unused and never wraps into termination

## Timing
- Launch latency: start sampled at edge k gives pulse=1 and busy=1 from edge k+1.
- Burst, N≥1: pulse high for H cycles, low for L cycles, repeated N times. There is no trailing LOW after the last pulse. Total busy cycles = N·H + (N−1)·L.
- done (or aborted) is asserted in the first cycle that busy=0. busy and pulse fall on the same edge.
- Gate mode: pulse follows start & ~stop with exactly 1 cycle of latency.
- Stop latency: 1 cycle from sampled stop to pulse=0.
- rst mid-burst: pulse drops immediately, asynchronously. No done or aborted strobe is generated for the interrupted burst.

## Test plan
- Reset: assert rst mid-burst on channel 0 with H=3 → pulse, busy, done and aborted are 0 at once. After release, the channel relaunches normally.
- Burst, gate_mode=0, H=2, L=3, N=3, start[0] for 1 cycle at edge k → pulse[0] high at k+1..2, k+6..7 and k+11..12. busy is 1 for k+1..k+12. done[0]=1 at k+13 only.
- Zero fields: cfg_high=0, cfg_low=0, N=2 → pulse pattern 1,0,1 and then done. Continuous N=0, H=1, L=1 → 1010… toggle until stop. Stop at edge m → pulse=0 from m+1, with aborted=1 for exactly 1 cycle.
- Gate mode: gate_mode=1, start[1]=1 for 4 cycles, with stop[1]=1 during the 3rd of those cycles → pulse[1] = 1,1,0,1, delayed 1 cycle. busy, done and aborted stay 0.
- Priority and independence:
  - start and stop high together in IDLE → no launch
  - start held through a burst → relaunch on the cycle after done
  - channels 0–3 launched on different cycles with different cfg_* values → each matches its own captured H/L/N
- Boundary: WIDTH_W=COUNT_W=4, H=15, L=15, N=15 → exactly 15 pulses of 15 cycles each. busy lasts 435 cycles, followed by one done strobe.
